// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side handshake of the PS/2 receive FIFO: show-ahead head byte,
// non-empty flag, fill level and pop request.
interface ps2_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic [7:0]          o_data;
  logic                o_valid;
  logic [DEPTH_LOG2:0] o_count;
  logic                i_ready;

  modport master (output o_data, output o_valid, output o_count, input i_ready);
  modport slave  (input o_data, input o_valid, input o_count, output i_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity, stop)
// feeding a small show-ahead byte FIFO with sticky error flags.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2  = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int OVERWRITE   = 0
) (
  input  logic          i_clk,
  input  logic          i_clr_n,
  input  logic          i_ps2_clk,
  input  logic          i_ps2_data,
  input  logic          i_err_clr,
  ps2_rx_fifo_if.master bus,
  output logic          o_overflow,
  output logic          o_parity_err,
  output logic          o_frame_err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FW    = $clog2(FILTER_LEN);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // bit 0 carries the PS/2 clock, bit 1 the PS/2 data; both idle high
  logic [1:0]    meta_reg, sync_reg;
  logic          filt_reg, filt_prev_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          strobe;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      meta_reg      <= 2'b11;
      sync_reg      <= 2'b11;
      filt_reg      <= 1'b1;
      filt_prev_reg <= 1'b1;
      filt_cnt_reg  <= '0;
    end else begin
      meta_reg      <= {i_ps2_data, i_ps2_clk};
      sync_reg      <= meta_reg;
      filt_prev_reg <= filt_reg;
      if (sync_reg[0] == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_reg     <= sync_reg[0];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FW'(1);
      end
    end
  end

  assign strobe = filt_prev_reg & ~filt_reg;

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          push, par_evt, frm_evt;

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      to_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      to_cnt_reg  <= to_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    to_cnt_next  = to_cnt_reg;
    push         = 1'b0;
    par_evt      = 1'b0;
    frm_evt      = 1'b0;
    case (state_reg)
      IDLE: begin
        to_cnt_next = '0;
        if (strobe && !sync_reg[1]) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: if (strobe) begin
        shift_next   = {sync_reg[1], shift_reg[7:1]};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = PARITY;
      end
      PARITY: if (strobe) begin
        par_next   = sync_reg[1];
        state_next = STOP;
      end
      STOP: if (strobe) begin
        // odd parity: data plus parity bit must hold an odd number of ones
        push       = sync_reg[1] & (^{shift_reg, par_reg});
        par_evt    = ~(^{shift_reg, par_reg});
        frm_evt    = ~sync_reg[1];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE) begin
      if (strobe) begin
        to_cnt_next = '0;
      end else if (to_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
        state_next  = IDLE;
        frm_evt     = 1'b1;
        to_cnt_next = '0;
      end else begin
        to_cnt_next = to_cnt_reg + TW'(1);
      end
    end
  end

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  overflow_reg, parity_err_reg, frame_err_reg;
  logic                  pop, full, wr_en, drop_oldest;

  assign full        = (count_reg == FULL_CNT);
  assign pop         = bus.i_ready & bus.o_valid;
  assign drop_oldest = push & full & ~pop & (OVERWRITE != 0);
  assign wr_en       = push & (~full | pop | (OVERWRITE != 0));

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop || drop_oldest) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !full && !pop) count_reg <= count_reg + 1'b1;
      else if (pop && !push)     count_reg <= count_reg - 1'b1;
      // a new error event takes priority over a clear in the same cycle
      if (push && full && !pop) overflow_reg <= 1'b1;
      else if (i_err_clr)       overflow_reg <= 1'b0;
      if (par_evt)        parity_err_reg <= 1'b1;
      else if (i_err_clr) parity_err_reg <= 1'b0;
      if (frm_evt)        frame_err_reg <= 1'b1;
      else if (i_err_clr) frame_err_reg <= 1'b0;
    end
  end

  // shallow FIFO: asynchronous read of the head gives show-ahead data
  assign bus.o_data    = mem[rd_ptr_reg];
  assign bus.o_valid   = (count_reg != '0);
  assign bus.o_count   = count_reg;
  assign o_overflow    = overflow_reg;
  assign o_parity_err  = parity_err_reg;
  assign o_frame_err   = frame_err_reg;
endmodule
